// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-cache line
// refill engine (fixed-length bursts) and a single-word data access port.
// Optional build macro MEM_ARBITER_RR_EN switches the IDLE-state tie-break
// from fixed data priority to round-robin between the two requesters.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_ireq,
  input  logic [ADDR_WIDTH-1:0] i_iaddr,
  output logic                  o_ivalid,
  output logic [DATA_WIDTH-1:0] o_irdata,
  output logic                  o_idone,
  input  logic                  i_dreq,
  input  logic                  i_dwe,
  input  logic [ADDR_WIDTH-1:0] i_daddr,
  input  logic [DATA_WIDTH-1:0] i_dwdata,
  output logic                  o_dack,
  output logic [DATA_WIDTH-1:0] o_drdata,
  output logic                  o_mem_rd,
  output logic                  o_mem_wr,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ready,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(BURST_LEN);
  localparam int OFF_W = CNT_W + 2;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IBURST  = 2'd1,
    DACCESS = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_beatCount;
  logic               w_lastBeat;
  logic               w_grantData;
  logic [ADDR_WIDTH-1:0] w_burstAddr;

`ifdef MEM_ARBITER_RR_EN
  // 1 = the instruction side won the most recent grant, so data wins a tie next
  logic r_lastInstr;
  assign w_grantData = i_dreq && (!i_ireq || r_lastInstr);
`else
  assign w_grantData = i_dreq;
`endif

  assign w_lastBeat  = (r_beatCount == CNT_W'(BURST_LEN - 1));
  assign w_burstAddr = (i_iaddr & LINE_MASK) + ADDR_WIDTH'({r_beatCount, 2'b00});

  // Transaction sequencer: grants in IDLE, counts refill beats, returns on completion
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_beatCount <= '0;
`ifdef MEM_ARBITER_RR_EN
      r_lastInstr <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantData) begin
            r_state <= DACCESS;
`ifdef MEM_ARBITER_RR_EN
            r_lastInstr <= 1'b0;
`endif
          end else if (i_ireq) begin
            r_state <= IBURST;
`ifdef MEM_ARBITER_RR_EN
            r_lastInstr <= 1'b1;
`endif
          end
        end
        IBURST: begin
          if (i_mem_ready) begin
            if (w_lastBeat) begin
              r_beatCount <= '0;
              r_state     <= IDLE;
            end else begin
              r_beatCount <= r_beatCount + 1'b1;
            end
          end
        end
        DACCESS: begin
          if (i_mem_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory strobes and requester handshakes decoded from the current state
  always_comb begin
    o_ivalid    = 1'b0;
    o_irdata    = '0;
    o_idone     = 1'b0;
    o_dack      = 1'b0;
    o_drdata    = '0;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_busy      = (r_state != IDLE);
    case (r_state)
      IBURST: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = w_burstAddr;
        o_irdata   = i_mem_rdata;
        o_ivalid   = i_mem_ready;
        o_idone    = i_mem_ready && w_lastBeat;
      end
      DACCESS: begin
        o_mem_rd    = ~i_dwe;
        o_mem_wr    = i_dwe;
        o_mem_addr  = i_daddr;
        o_mem_wdata = i_dwdata;
        o_dack      = i_mem_ready;
        o_drdata    = i_dwe ? '0 : i_mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter BURST_LEN, default 4, words per instruction-cache line refill (power of two, 2..16).
REQ-004 SHALL have ports, one per line:
- i_clock  in  1  sole clock, rising-edge active
- i_reset  in  1  asynchronous, active-high reset
- i_ireq  in  1  instruction-cache line-refill request
- i_iaddr  in  ADDR_WIDTH  refill address; line offset bits ignored
- o_ivalid  out  1  refill beat valid
- o_irdata  out  DATA_WIDTH  refill beat data
- o_idone  out  1  last refill beat
- i_dreq  in  1  data access request
- i_dwe  in  1  1 = write, 0 = read
- i_daddr  in  ADDR_WIDTH  data word address
- i_dwdata  in  DATA_WIDTH  write data
- o_dack  out  1  data access complete
- o_drdata  out  DATA_WIDTH  read data
- o_mem_rd  out  1  memory read strobe
- o_mem_wr  out  1  memory write strobe
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  memory read data
- i_mem_ready  in  1  memory completes current beat this cycle
- o_busy  out  1  transaction in progress

Function
REQ-005 SHALL implement states IDLE, IBURST, DACCESS; o_busy = (state != IDLE).
REQ-006 In IDLE, request sampled at a rising edge SHALL move state to IBURST or DACCESS at that edge; memory strobes SHALL assert the following cycle.
REQ-007 Default priority: i_dreq wins over i_ireq when both high in IDLE.
REQ-008 In IBURST: o_mem_rd=1, o_mem_addr = line base of i_iaddr (low log2(BURST_LEN)+2 bits zeroed) + 4*beat counter.
REQ-009 Each IBURST cycle with i_mem_ready=1: o_ivalid=1, o_irdata=i_mem_rdata (combinational), counter increments.
REQ-010 On beat BURST_LEN-1 with i_mem_ready=1: o_idone=1 with o_ivalid, counter wraps to 0, state returns to IDLE.
REQ-011 In DACCESS: o_mem_addr=i_daddr, o_mem_wdata=i_dwdata, o_mem_rd=~i_dwe, o_mem_wr=i_dwe.
REQ-012 DACCESS with i_mem_ready=1: o_dack=1 one cycle, o_drdata=i_mem_rdata (reads), return to IDLE.
REQ-013 i_mem_ready=0 SHALL stall the current beat, holding address and strobes unchanged.
REQ-014 Requesters hold req/addr/data stable until o_idone/o_dack; deasserting request mid-transaction SHALL NOT abort it.
REQ-015 Zero-wait latency: data access = 1 cycle after grant; refill = BURST_LEN cycles after grant; one IDLE cycle between transactions.
REQ-016 Outside IBURST/DACCESS all strobes, o_ivalid, o_idone, o_dack SHALL be 0; o_mem_addr, o_mem_wdata, o_irdata, o_drdata SHALL be 0 in IDLE.

Reset
REQ-017 i_reset high SHALL immediately force IDLE, beat counter 0, priority flag to "instruction granted last", all outputs 0.
REQ-018 Reset mid-burst or mid-access SHALL discard the transaction; no o_idone/o_dack is produced.

Configuration
REQ-019 Macro MEM_ARBITER_RR_EN defined: when both request in IDLE, grant the requester not granted most recently (flag updated on each grant); undefined: fixed data priority per REQ-007, flag logic absent.

Verification
REQ-020 i_dreq=1, i_dwe=0, i_daddr=0x100, ready=1, rdata=0xCAFEBABE -> o_mem_rd cycle 1, o_dack=1, o_drdata=0xCAFEBABE, back to IDLE.
REQ-021 i_ireq=1, i_iaddr=0x1238, ready=1 -> o_mem_addr 0x1230,0x1234,0x1238,0x123C; four o_ivalid; o_idone on 4th.
REQ-022 Refill with ready low in beat 2 for 3 cycles -> address 0x1238 held 4 cycles, exactly 4 o_ivalid pulses total.
REQ-023 i_ireq and i_dreq high together, three transactions -> without macro all data first; with MEM_ARBITER_RR_EN grants alternate D, I, D.
REQ-024 i_reset pulsed during beat 1 of refill -> outputs 0 asynchronously, no o_idone, next i_dreq write 0x55 to 0x200 completes normally.
